// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle: ID/EX/MEM status in, stall/flush/bubble controls out.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       ex_memread;
  logic [4:0] ex_wreg;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_nop;
  logic       exmem_stall;
  logic       memwb_nop;
  logic       mem_err;
  logic [1:0] state;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wreg,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_nop, exmem_stall,
           memwb_nop, mem_err, state
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wreg,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_nop, exmem_stall,
           memwb_nop, mem_err, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use bubbles, branch flush, memory wait stall with timeout.
// Optional macro HAZARD_STAT_EN adds saturating stall_cnt / flush_cnt statistics outputs.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_STAT_EN
  ,
  output logic [15:0]  stall_cnt,
  output logic [15:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic load_use;
  logic pc_stall;
  logic ifid_stall;
  logic ifid_flush;
  logic idex_nop;
  logic exmem_stall;
  logic memwb_nop;
  logic mem_err;

  assign load_use = bus.ex_memread && (bus.ex_wreg != 5'd0) &&
                    ((bus.id_use_rs && (bus.id_rs == bus.ex_wreg)) ||
                     (bus.id_use_rt && (bus.id_rt == bus.ex_wreg)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // A memory stall freezes everything up to MEM-WB and overrides branch/load-use;
  // otherwise a taken branch wins over a load-use bubble since the ID instruction is squashed.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_nop     = 1'b0;
    exmem_stall  = 1'b0;
    memwb_nop    = 1'b0;
    mem_err      = 1'b0;

    case (state)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          exmem_stall  = 1'b1;
          memwb_nop    = 1'b1;
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd0;
        end else if (bus.ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_nop   = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_nop   = 1'b1;
        end
      end

      WAIT: begin
        if (!bus.mem_ready) begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          exmem_stall  = 1'b1;
          memwb_nop    = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ERR;
          end
        end else begin
          state_nxt = RUN;
          if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_nop   = 1'b1;
          end
        end
      end

      ERR: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_nop   = 1'b1;
        mem_err     = 1'b1;
      end

      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_nop    = idex_nop;
  assign bus.exmem_stall = exmem_stall;
  assign bus.memwb_nop   = memwb_nop;
  assign bus.mem_err     = mem_err;
  assign bus.state       = state;

`ifdef HAZARD_STAT_EN
  // Counters saturate rather than wrap so a long-running profile never reads as low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (pc_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (ifid_flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4); counter checks only when HAZARD_STAT_EN is defined.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hazard_ctrl_if hif ();

`ifdef HAZARD_STAT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: {pc_stall, ifid_stall, ifid_flush, idex_nop, exmem_stall, memwb_nop, mem_err, state[1:0]}
  localparam logic [8:0] IDLE_RUN   = 9'b0000000_00;
  localparam logic [8:0] LU_RUN     = 9'b1101000_00;
  localparam logic [8:0] BR_RUN     = 9'b0011000_00;
  localparam logic [8:0] STALL_RUN  = 9'b1100110_00;
  localparam logic [8:0] STALL_WAIT = 9'b1100110_01;
  localparam logic [8:0] IDLE_WAIT  = 9'b0000000_01;
  localparam logic [8:0] BR_WAIT    = 9'b0011000_01;
  localparam logic [8:0] ERR_V      = 9'b1100111_10;

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic use_rs, input logic use_rt,
                               input logic memread, input logic [4:0] wreg,
                               input logic branch, input logic mreq,
                               input logic mready);
    hif.id_rs           = rs;
    hif.id_rt           = rt;
    hif.id_use_rs       = use_rs;
    hif.id_use_rt       = use_rt;
    hif.ex_memread      = memread;
    hif.ex_wreg         = wreg;
    hif.ex_branch_taken = branch;
    hif.mem_req         = mreq;
    hif.mem_ready       = mready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] expv);
    logic [8:0] obs;
    obs = {hif.pc_stall, hif.ifid_stall, hif.ifid_flush, hif.idex_nop,
           hif.exmem_stall, hif.memwb_nop, hif.mem_err, hif.state};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_STAT_EN
  task automatic checkCounts(input string tag, input logic [15:0] exp_stall,
                             input logic [15:0] exp_flush);
    total++;
    assert (stall_cnt === exp_stall) else begin
      bad++;
      $error("[TB] FAIL %s_stall observed=%0d expected=%0d", tag, stall_cnt, exp_stall);
    end
    total++;
    assert (flush_cnt === exp_flush) else begin
      bad++;
      $error("[TB] FAIL %s_flush observed=%0d expected=%0d", tag, flush_cnt, exp_flush);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("reset", IDLE_RUN);

    // Load-use on rs: bubble only while present
    applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs", LU_RUN);
    tick();
    applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_gone", IDLE_RUN);
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_r0", IDLE_RUN);
    applyStimulus(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_norsuse", IDLE_RUN);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rt", LU_RUN);
    applyStimulus(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rtnouse", IDLE_RUN);

    // Branch beats load-use
    applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("br_lu", BR_RUN);
    tick();

    // Timeout to ERR: 1 RUN stall + 4 WAIT stalls
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_run", STALL_RUN);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_wait%0d", i), STALL_WAIT);
      tick();
    end
    checkOutput("to_err", ERR_V);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("err_sticky", ERR_V);

    // Reset from ERR; outputs after the edge follow RUN decoding of inputs
    rst_n = 1'b0;
    applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("err_prereset", ERR_V);
    tick();
    checkOutput("err_reset", LU_RUN);
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("post_reset", IDLE_RUN);

    // Reset mid-WAIT
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("midwait", STALL_WAIT);
    rst_n = 1'b0;
    tick();
    checkOutput("midwait_reset", STALL_RUN);
    rst_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("midwait_idle", IDLE_RUN);
`ifdef HAZARD_STAT_EN
    checkCounts("cnt_zero", 16'd0, 16'd0);
`endif

    // Three-cycle memory wait, load-use masked under stall
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("mw1", STALL_RUN);
    tick();
    applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
    checkOutput("mw2_lu", STALL_WAIT);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("mw3", STALL_WAIT);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_release", IDLE_WAIT);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mw_back", IDLE_RUN);
`ifdef HAZARD_STAT_EN
    checkCounts("cnt_mw", 16'd3, 16'd0);
`endif

    // Branch held under memory stall flushes on release
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("bs1", STALL_RUN);
    tick();
    checkOutput("bs2", STALL_WAIT);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("bs_release", BR_WAIT);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bs_back", IDLE_RUN);
`ifdef HAZARD_STAT_EN
    checkCounts("cnt_bs", 16'd5, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, WAIT-state cycles tolerated before declaring a memory error (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the ID-stage instruction.
REQ-005 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-006 ex_memread  input  1  EX-stage instruction is a load.
REQ-007 ex_wreg  input  5  EX-stage destination register.
REQ-008 ex_branch_taken  input  1  branch resolved taken in EX.
REQ-009 mem_req  input  1  MEM-stage instruction accesses data memory.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_stall, ifid_stall  output  1 each  hold PC / IF-ID register.
REQ-012 ifid_flush  output  1  clear IF-ID register to a nop.
REQ-013 idex_nop  output  1  drives the nop input of the ID-stage control-zeroing logic (bubble into ID-EX).
REQ-014 exmem_stall  output  1  hold ID-EX and EX-MEM registers.
REQ-015 memwb_nop  output  1  insert a bubble into MEM-WB.
REQ-016 mem_err  output  1  sticky memory-timeout flag.
REQ-017 state  output  2  current FSM state (RUN=0, WAIT=1, ERR=2).

Function
REQ-018 The FSM SHALL have states RUN, WAIT and ERR; state and wait_cnt (8-bit) are the only registers outside the REQ-030 counters.
REQ-019 Load-use hazard SHALL be ex_memread && ex_wreg!=0 && ((id_use_rs && id_rs==ex_wreg) || (id_use_rt && id_rt==ex_wreg)).
REQ-020 In RUN with mem_req && !mem_ready: pc_stall=ifid_stall=exmem_stall=memwb_nop=1, idex_nop=0, ifid_flush=0, same cycle; next state WAIT, wait_cnt<=0.
REQ-021 In WAIT with !mem_ready: outputs as REQ-020; wait_cnt increments; if wait_cnt==MEM_TIMEOUT-1, next state ERR.
REQ-022 In WAIT with mem_ready: all stall/nop/flush outputs 0 this cycle except those set by REQ-023/REQ-024; next state RUN.
REQ-023 In RUN (no memory stall) or WAIT-with-mem_ready, ex_branch_taken SHALL assert ifid_flush=1 and idex_nop=1, pc_stall=0, ifid_stall=0, same cycle; a coincident load-use hazard is ignored.
REQ-024 Otherwise a load-use hazard SHALL assert pc_stall=ifid_stall=idex_nop=1 for exactly the cycle it is present (one bubble).
REQ-025 Memory stall SHALL take priority over branch flush and load-use; a branch held under a memory stall is acted on in the release cycle.
REQ-026 In ERR: pc_stall=ifid_stall=exmem_stall=memwb_nop=1, mem_err=1; ERR is left only by reset.
REQ-027 All hazard decisions are combinational from inputs and current state (zero-cycle latency); no output depends on a stale registered hazard.

Reset
REQ-028 While rst_n=0 at a rising edge: state<=RUN, wait_cnt<=0, mem_err cleared, REQ-030 counters cleared; reset mid-WAIT or in ERR returns to RUN next cycle.
REQ-029 During the reset cycle, outputs SHALL follow RUN decoding of the current inputs after the edge; no output is forced other than via state.

Configuration
REQ-030 Macro HAZARD_STAT_EN: when defined, adds outputs stall_cnt[15:0] (counts cycles with pc_stall=1) and flush_cnt[15:0] (counts cycles with ifid_flush=1), both saturating at 16'hFFFF; when undefined, these ports and registers do not exist and all other behaviour is identical.

Verification
REQ-031 ex_memread=1, ex_wreg=8, id_rs=8, id_use_rs=1 for one cycle -> pc_stall=ifid_stall=idex_nop=1 that cycle only, exmem_stall=0.
REQ-032 Same as REQ-031 but ex_wreg=0 -> no stall; and with id_use_rs=0 -> no stall.
REQ-033 ex_branch_taken=1 with simultaneous load-use -> ifid_flush=1, idex_nop=1, pc_stall=0.
REQ-034 mem_req=1, mem_ready low 3 cycles then high -> 3 cycles of full stall + memwb_nop, state RUN->WAIT->WAIT->RUN, release cycle stalls 0.
REQ-035 MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> state ERR after 5 stalled cycles, mem_err=1 sticky; rst_n=0 one cycle -> RUN, mem_err=0.
REQ-036 With HAZARD_STAT_EN, REQ-034 sequence -> stall_cnt=3, flush_cnt=0; branch under memory stall -> flush on release cycle, flush_cnt=1.
